// File: rtl/issue_scoreboard_ctrl.sv
// Dual-issue scheduler: decides how many queue-head instructions dispatch each cycle using a
// per-register countdown scoreboard, intra-pair dependency checks and structural pairing rules.
module issue_scoreboard_ctrl #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_valid,
    input  logic [4:0]       i_rs1_a,
    input  logic [4:0]       i_rs2_a,
    input  logic [4:0]       i_rs1_b,
    input  logic [4:0]       i_rs2_b,
    input  logic [4:0]       i_rd_a,
    input  logic [4:0]       i_rd_b,
    input  logic             i_we_a,
    input  logic             i_we_b,
    input  logic             i_ld_a,
    input  logic             i_ld_b,
    input  logic             i_mem_a,
    input  logic             i_mem_b,
    input  logic             i_br_a,
    input  logic             i_br_b,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [1:0]       o_usingNUM,
    output logic             o_issue_a,
    output logic             o_issue_b,
    output logic [NREG-1:0]  o_busy_vec,
    output logic [CNT_W-1:0] o_cnt_cycle,
    output logic [CNT_W-1:0] o_cnt_dual,
    output logic [CNT_W-1:0] o_cnt_hazard
);

    localparam int unsigned MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int unsigned TW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    localparam int unsigned RW      = 5;

    logic [TW-1:0] timer     [NREG];
    logic [TW-1:0] timer_nxt [NREG];

    logic rdy_rs1_a, rdy_rs2_a, rdy_rs1_b, rdy_rs2_b;
    logic dep, waw, struct_ok;
    logic issue_a, issue_b;

    // Busy vector doubles as the readiness lookup for all four sources
    always_comb begin
        o_busy_vec = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            o_busy_vec[i] = (timer[i] != '0);
        end
    end

    always_comb begin
        rdy_rs1_a = (i_rs1_a == RW'(0)) || !o_busy_vec[i_rs1_a];
        rdy_rs2_a = (i_rs2_a == RW'(0)) || !o_busy_vec[i_rs2_a];
        rdy_rs1_b = (i_rs1_b == RW'(0)) || !o_busy_vec[i_rs1_b];
        rdy_rs2_b = (i_rs2_b == RW'(0)) || !o_busy_vec[i_rs2_b];
    end

    // Pairing rules: slot2 may not read or overwrite slot1's result, nor share a mem port or branch unit
    always_comb begin
        dep       = i_we_a && (i_rd_a != RW'(0)) && ((i_rs1_b == i_rd_a) || (i_rs2_b == i_rd_a));
        waw       = i_we_a && i_we_b && (i_rd_a == i_rd_b) && (i_rd_a != RW'(0));
        struct_ok = !(i_mem_a && i_mem_b) && !(i_br_a && i_br_b);
    end

    // Reset also suppresses dispatch so the queue never pops while the scoreboard is being cleared
    always_comb begin
        issue_a = i_valid[1] && !i_stall && !i_flush && !rst && rdy_rs1_a && rdy_rs2_a;
        issue_b = issue_a && i_valid[0] && rdy_rs1_b && rdy_rs2_b && !dep && !waw && struct_ok;
    end

    assign o_issue_a  = issue_a;
    assign o_issue_b  = issue_b;
    assign o_usingNUM = 2'(issue_a) + 2'(issue_b);

    // Countdown update; a freshly issued producer overrides the decrement on its destination
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            timer_nxt[i] = timer[i];
        end
        if (!i_stall) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (timer[i] != '0) begin
                    timer_nxt[i] = timer[i] - TW'(1);
                end
            end
            if (issue_a && i_we_a && (i_rd_a != RW'(0))) begin
                timer_nxt[i_rd_a] = i_ld_a ? TW'(LOAD_LAT) : TW'(ALU_LAT);
            end
            if (issue_b && i_we_b && (i_rd_b != RW'(0))) begin
                timer_nxt[i_rd_b] = i_ld_b ? TW'(LOAD_LAT) : TW'(ALU_LAT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                timer[i] <= timer_nxt[i];
            end
        end
    end

    // Performance counters, free-running modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cnt_cycle  <= '0;
            o_cnt_dual   <= '0;
            o_cnt_hazard <= '0;
        end else begin
            o_cnt_cycle <= o_cnt_cycle + CNT_W'(1);
            if (o_usingNUM == 2'd2) begin
                o_cnt_dual <= o_cnt_dual + CNT_W'(1);
            end
            if (i_valid[1] && (o_usingNUM == 2'd0)) begin
                o_cnt_hazard <= o_cnt_hazard + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Scoreboard bench for issue_scoreboard_ctrl: expected dispatch pushed at drive time, popped at sample.
module tb_issue_scoreboard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       mem;
        logic       br;
    } ins_t;

    logic        clk, rst;
    logic [1:0]  i_valid;
    ins_t        ia, ib;
    logic        i_stall, i_flush;
    logic [1:0]  o_usingNUM;
    logic        o_issue_a, o_issue_b;
    logic [31:0] o_busy_vec, o_cnt_cycle, o_cnt_dual, o_cnt_hazard;

    logic [3:0]  sb[$];
    logic [3:0]  got, e;
    logic [1:0]  last_num;
    int unsigned checks = 0, failures = 0;
    int unsigned m_cycle = 0, m_dual = 0, m_hazard = 0;

    issue_scoreboard_ctrl dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .i_rs1_a(ia.rs1), .i_rs2_a(ia.rs2), .i_rs1_b(ib.rs1), .i_rs2_b(ib.rs2),
        .i_rd_a(ia.rd), .i_rd_b(ib.rd), .i_we_a(ia.we), .i_we_b(ib.we),
        .i_ld_a(ia.ld), .i_ld_b(ib.ld), .i_mem_a(ia.mem), .i_mem_b(ib.mem),
        .i_br_a(ia.br), .i_br_b(ib.br), .i_stall(i_stall), .i_flush(i_flush),
        .o_usingNUM(o_usingNUM), .o_issue_a(o_issue_a), .o_issue_b(o_issue_b),
        .o_busy_vec(o_busy_vec), .o_cnt_cycle(o_cnt_cycle), .o_cnt_dual(o_cnt_dual),
        .o_cnt_hazard(o_cnt_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        alu = '{rs1: rs1, rs2: rs2, rd: rd, we: 1'b1, ld: 1'b0, mem: 1'b0, br: 1'b0};
    endfunction
    function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] rs1);
        ld = '{rs1: rs1, rs2: 5'd0, rd: rd, we: 1'b1, ld: 1'b1, mem: 1'b1, br: 1'b0};
    endfunction
    function automatic ins_t st(input logic [4:0] rs1, input logic [4:0] rs2);
        st = '{rs1: rs1, rs2: rs2, rd: 5'd0, we: 1'b0, ld: 1'b0, mem: 1'b1, br: 1'b0};
    endfunction
    function automatic ins_t br(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        br = '{rs1: rs1, rs2: rs2, rd: rd, we: (rd != 5'd0), ld: 1'b0, mem: 1'b0, br: 1'b1};
    endfunction

    // Drive one cycle of stimulus, push its expected dispatch, and move to the sampling edge
    task automatic step(input ins_t a, input ins_t b, input logic [1:0] v, input logic stl,
                        input logic fl, input logic [1:0] n);
        ia = a; ib = b; i_valid = v; i_stall = stl; i_flush = fl;
        sb.push_back({n != 2'd0, n == 2'd2, n});
        last_num = n;
        @(negedge clk);
    endtask

    // Advance through the active edge and mirror the counter behaviour
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cycle = 0; m_dual = 0; m_hazard = 0;
        end else begin
            m_cycle++;
            if (last_num == 2'd2) m_dual++;
            if (i_valid[1] && last_num == 2'd0) m_hazard++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(alu(5'd1, 5'd2, 5'd3), alu(5'd4, 5'd5, 5'd6), 2'b11, 1'b0, 1'b0, 2'd0);
            got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL reset_issue: got=%b exp=%b", got, e); end
            tick();
        end
        rst = 1'b0;
        checks++;
        if (o_busy_vec !== 32'd0) begin failures++; $display("FAIL reset_busy: got=%h exp=0", o_busy_vec); end
        checks++;
        if ({o_cnt_cycle, o_cnt_dual, o_cnt_hazard} !== 96'd0) begin
            failures++; $display("FAIL reset_cnt: got=%0d/%0d/%0d exp=0/0/0", o_cnt_cycle, o_cnt_dual, o_cnt_hazard);
        end
        step(alu(5'd1, 5'd2, 5'd3), alu(5'd4, 5'd5, 5'd6), 2'b11, 1'b0, 1'b0, 2'd2);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL post_reset_pair: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_cnt_cycle !== 32'd1) begin failures++; $display("FAIL cnt_cycle_first: got=%0d exp=1", o_cnt_cycle); end
    endtask

    task automatic test_load_use();
        step(ld(5'd5, 5'd2), alu(5'd6, 5'd5, 5'd1), 2'b11, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL ld_pair_dep: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_busy_vec !== 32'h20) begin failures++; $display("FAIL ld_busy5: got=%h exp=00000020", o_busy_vec); end
        step(alu(5'd6, 5'd5, 5'd1), '0, 2'b10, 1'b0, 1'b0, 2'd0);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL ld_use_bubble: got=%b exp=%b", got, e); end
        tick();
        step(alu(5'd6, 5'd5, 5'd1), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL ld_use_issue: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_cnt_hazard !== 32'(m_hazard) || m_hazard != 1) begin
            failures++; $display("FAIL cnt_hazard_ld: got=%0d exp=1", o_cnt_hazard);
        end
    endtask

    task automatic test_alu_chain();
        step(alu(5'd3, 5'd1, 5'd2), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL alu_first: got=%b exp=%b", got, e); end
        tick();
        step(alu(5'd4, 5'd3, 5'd1), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL alu_chain: got=%b exp=%b", got, e); end
        tick();
    endtask

    task automatic test_structural();
        ins_t pa[4], pb[4];
        logic [1:0] pn[4];
        pa[0] = st(5'd1, 5'd2);             pb[0] = ld(5'd8, 5'd3);           pn[0] = 2'd1;
        pa[1] = br(5'd0, 5'd1, 5'd2);       pb[1] = br(5'd31, 5'd0, 5'd0);    pn[1] = 2'd1;
        pa[2] = alu(5'd7, 5'd1, 5'd2);      pb[2] = alu(5'd7, 5'd3, 5'd4);    pn[2] = 2'd1;
        pa[3] = alu(5'd10, 5'd1, 5'd2);     pb[3] = ld(5'd11, 5'd12);         pn[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            step(pa[k], pb[k], 2'b11, 1'b0, 1'b0, pn[k]);
            got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL struct_%0d: got=%b exp=%b", k, got, e); end
            tick();
        end
        checks++;
        if (o_cnt_dual !== 32'(m_dual)) begin failures++; $display("FAIL cnt_dual: got=%0d exp=%0d", o_cnt_dual, m_dual); end
        checks++;
        if (o_busy_vec !== 32'h800) begin failures++; $display("FAIL struct_busy11: got=%h exp=00000800", o_busy_vec); end
        tick();
    endtask

    task automatic test_stall();
        step(ld(5'd9, 5'd1), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL stall_ld: got=%b exp=%b", got, e); end
        tick();
        for (int k = 0; k < 3; k++) begin
            step(alu(5'd13, 5'd9, 5'd0), alu(5'd14, 5'd1, 5'd2), 2'b11, 1'b1, 1'b0, 2'd0);
            got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL stall_hold_%0d: got=%b exp=%b", k, got, e); end
            tick();
            checks++;
            if (o_busy_vec[9] !== 1'b1) begin failures++; $display("FAIL stall_busy9_%0d: got=%b exp=1", k, o_busy_vec[9]); end
        end
        step(alu(5'd13, 5'd9, 5'd0), '0, 2'b10, 1'b0, 1'b0, 2'd0);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL stall_release_wait: got=%b exp=%b", got, e); end
        tick();
        step(alu(5'd13, 5'd9, 5'd0), alu(5'd14, 5'd1, 5'd2), 2'b11, 1'b0, 1'b0, 2'd2);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL stall_consumer: got=%b exp=%b", got, e); end
        tick();
    endtask

    task automatic test_flush_r0();
        step(alu(5'd15, 5'd1, 5'd2), alu(5'd16, 5'd3, 5'd4), 2'b11, 1'b0, 1'b1, 2'd0);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL flush_block: got=%b exp=%b", got, e); end
        tick();
        step(ld(5'd14, 5'd1), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL flush_ld: got=%b exp=%b", got, e); end
        tick();
        step(alu(5'd17, 5'd14, 5'd0), '0, 2'b10, 1'b0, 1'b1, 2'd0);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL flush_dep: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_busy_vec !== 32'd0) begin failures++; $display("FAIL flush_decay: got=%h exp=0", o_busy_vec); end
        step(ld(5'd0, 5'd2), alu(5'd1, 5'd0, 5'd0), 2'b11, 1'b0, 1'b0, 2'd2);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL r0_pair: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_busy_vec !== 32'd0) begin failures++; $display("FAIL r0_busy: got=%h exp=0", o_busy_vec); end
        step(alu(5'd1, 5'd0, 5'd0), '0, 2'b10, 1'b0, 1'b0, 2'd1);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL r0_consumer: got=%b exp=%b", got, e); end
        tick();
    endtask

    task automatic test_counters();
        step('0, '0, 2'b00, 1'b0, 1'b0, 2'd0);
        got = {o_issue_a, o_issue_b, o_usingNUM}; e = sb.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL idle_zero: got=%b exp=%b", got, e); end
        tick();
        checks++;
        if (o_cnt_cycle !== 32'(m_cycle)) begin failures++; $display("FAIL cnt_cycle: got=%0d exp=%0d", o_cnt_cycle, m_cycle); end
        checks++;
        if (o_cnt_dual !== 32'(m_dual)) begin failures++; $display("FAIL cnt_dual_end: got=%0d exp=%0d", o_cnt_dual, m_dual); end
        checks++;
        if (o_cnt_hazard !== 32'(m_hazard)) begin failures++; $display("FAIL cnt_hazard_end: got=%0d exp=%0d", o_cnt_hazard, m_hazard); end
    endtask

    initial begin
        ia = '0; ib = '0; i_valid = 2'b00; i_stall = 1'b0; i_flush = 1'b0; rst = 1'b1; last_num = 2'd0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_alu_chain();
        test_structural();
        test_stall();
        test_flush_r0();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
